// File: rtl/instr_prefetch_pkg.sv
// Shared B32P fetch constants: instruction/address widths, reset vector and fetch FSM encoding.
package instr_prefetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 27;

    localparam logic [ADDR_W-1:0] RESET_ADDR = 27'd0;
    localparam logic [ADDR_W-1:0] PC_ONE     = 27'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // Sequential PC step; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + PC_ONE;
    endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; clear empties it in one cycle.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 59
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage array; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; clear has priority over push and pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: runs ahead of the CPU over a single-outstanding req/ack port,
// buffers words with their PCs and restarts cleanly on a flush redirect.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_q,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_e       state_r;
    logic [ADDR_W-1:0]  fetch_pc_r;

    logic               ack_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_pop_s;
    logic               room_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   count_next_s;
    logic [ENT_W-1:0]   head_s;

    // Handshake decode and occupancy after this cycle's push/pop.
    always_comb begin
        ack_s        = mem_ack & mem_req;
        pop_s        = instr_ready & ~empty_s;
        fifo_pop_s   = pop_s & ~flush;
        push_s       = ack_s & (state_r == REQ) & ~flush & ~full_s;
        count_next_s = count_s + CNT_W'(push_s) - CNT_W'(fifo_pop_s);
        room_s       = (count_next_s < CNT_W'(DEPTH));
    end

    // Fetch FSM with registered memory-port outputs; flush outranks everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_ADDR;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_ADDR;
        end else if (flush) begin
            fetch_pc_r <= flush_addr;
            mem_req    <= 1'b1;
            if ((state_r == REQ || state_r == DISCARD) && !ack_s) begin
                // Abandoned request still owes an ack; keep its address on the bus.
                state_r <= DISCARD;
            end else begin
                state_r  <= REQ;
                mem_addr <= flush_addr;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (room_s) begin
                        state_r  <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc_r;
                    end else begin
                        mem_req  <= 1'b0;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        fetch_pc_r <= pc_inc(fetch_pc_r);
                        if (room_s) begin
                            mem_addr <= pc_inc(fetch_pc_r);
                            mem_req  <= 1'b1;
                        end else begin
                            state_r  <= IDLE;
                            mem_req  <= 1'b0;
                        end
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (ack_s) begin
                        state_r  <= REQ;
                        mem_addr <= fetch_pc_r;
                    end else begin
                        state_r  <= DISCARD;
                    end
                    mem_req <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push_s),
        .pop   (fifo_pop_s),
        .din   ({fetch_pc_r, mem_q}),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign instr_valid = ~empty_s;
    assign instr_pc    = head_s[ENT_W-1:INSTR_W];
    assign instr       = head_s[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-based reference of the delivered instruction stream,
// directed scenarios plus randomized latency/ready/flush traffic.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic [ADDR_W-1:0]  flush_addr = 27'd0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack = 1'b0;
    logic [31:0]        mem_q = 32'd0;
    logic               instr_valid;
    logic [31:0]        instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_q       (mem_q),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       w;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Reference: words the CPU must still see, in order, and the next address to fetch.
    ent_t              mq[$];
    logic [ADDR_W-1:0] m_pc;
    bit                stale;
    logic [ADDR_W-1:0] stale_addr;
    int                mem_lat = 1;
    int                mem_w = 0;
    bit                last_flush;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return {5'h15, a} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (mq.size() > 0) begin
            chk("valid", {63'd0, instr_valid}, 64'd1);
            chk("instr_pc", {37'd0, instr_pc}, {37'd0, mq[0].pc});
            chk("instr", {32'd0, instr}, {32'd0, mq[0].w});
        end else begin
            chk("empty_valid", {63'd0, instr_valid}, 64'd0);
        end
        if (mem_req) begin
            chk("mem_addr", {37'd0, mem_addr}, {37'd0, (stale ? stale_addr : m_pc)});
        end
        if (mq.size() == DEPTH && !stale) begin
            chk("full_no_req", {63'd0, mem_req}, 64'd0);
        end
    endtask

    // One cycle: check outputs at negedge, then drive memory/CPU inputs and advance the reference.
    task automatic step(input bit f, input logic [ADDR_W-1:0] fa, input bit rdy, input bit f_on_ack);
        bit ack;
        bit do_f;
        bit pop;
        logic req_o;
        logic [ADDR_W-1:0] aa;
        @(negedge clk);
        compare();
        req_o = mem_req;
        aa    = mem_addr;
        ack   = 1'b0;
        if (mem_req) begin
            if (mem_w >= mem_lat) begin
                ack   = 1'b1;
                mem_w = 0;
            end else begin
                mem_w++;
            end
        end else begin
            mem_w = 0;
        end
        mem_ack     = ack;
        mem_q       = ack ? word_of(aa) : 32'hDEAD_BEEF;
        do_f        = f | (f_on_ack & ack);
        flush       = do_f;
        flush_addr  = fa;
        instr_ready = rdy;
        last_flush  = do_f;
        pop = (mq.size() > 0) && rdy;
        if (do_f) begin
            mq.delete();
            if (ack) begin
                stale = 1'b0;
            end else if (req_o && !stale) begin
                stale      = 1'b1;
                stale_addr = aa;
            end
            m_pc = fa;
        end else begin
            if (pop) void'(mq.pop_front());
            if (ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    mq.push_back('{m_pc, word_of(m_pc)});
                    m_pc = m_pc + 27'd1;
                    chk("no_overflow", {63'd0, (mq.size() <= DEPTH)}, 64'd1);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        mem_w       = 0;
        mq.delete();
        stale       = 1'b0;
        m_pc        = RESET_ADDR;
        @(negedge clk);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_pc", {37'd0, instr_pc}, 64'd0);
        reset = 1'b0;
    endtask

    task automatic run_until_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 27'd0, 1'b1, 1'b0);
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout waiting for instr_valid, got 0 expected 1", name);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;

        // 1: streaming with one-cycle ack latency.
        mem_lat = 1;
        do_reset();
        step(1'b0, 27'd0, 1'b1, 1'b0);
        step(1'b0, 27'd0, 1'b1, 1'b0);
        chk("t1_not_yet", {63'd0, instr_valid}, 64'd0);
        step(1'b0, 27'd0, 1'b1, 1'b0);
        chk("t1_first_valid", {63'd0, instr_valid}, 64'd1);
        chk("t1_pc0", {37'd0, instr_pc}, 64'd0);
        chk("t1_word0", {32'd0, instr}, {32'd0, 32'hBA34_5678});
        run_until_valid("t1_wait1");
        chk("t1_pc1", {37'd0, instr_pc}, 64'd1);
        repeat (20) step(1'b0, 27'd0, 1'b1, 1'b0);

        // 2: CPU stalled, FIFO fills to DEPTH then drains in order.
        mem_lat = 0;
        do_reset();
        repeat (20) step(1'b0, 27'd0, 1'b0, 1'b0);
        chk("t2_valid", {63'd0, instr_valid}, 64'd1);
        chk("t2_req_low", {63'd0, mem_req}, 64'd0);
        chk("t2_head0", {37'd0, instr_pc}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 27'd0, 1'b1, 1'b0);
            chk("t2_drain_pc", {37'd0, instr_pc}, 64'(i));
            if (i == 1) chk("t2_resume_addr", {37'd0, mem_addr}, 64'd4);
        end

        // 3: flush while the request for address 5 is outstanding.
        mem_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 27'd0, 1'b1, 1'b0);
            if (mem_req && mem_addr == 27'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("t3_reached_addr5", {63'd0, found}, 64'd1);
        step(1'b1, 27'h100, 1'b1, 1'b0);
        step(1'b0, 27'd0, 1'b1, 1'b0);
        chk("t3_discard_addr", {37'd0, mem_addr}, 64'd5);
        run_until_valid("t3_wait100");
        chk("t3_pc100", {37'd0, instr_pc}, 64'h100);
        run_until_valid("t3_wait101");
        chk("t3_pc101", {37'd0, instr_pc}, 64'h101);

        // 4: flush coinciding with mem_ack.
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 27'h200, 1'b1, 1'b1);
            if (last_flush) break;
        end
        chk("t4_flushed", {63'd0, last_flush}, 64'd1);
        step(1'b0, 27'd0, 1'b1, 1'b0);
        chk("t4_req", {63'd0, mem_req}, 64'd1);
        chk("t4_addr", {37'd0, mem_addr}, 64'h200);
        chk("t4_empty", {63'd0, instr_valid}, 64'd0);

        // 5: PC wraps at 2^27.
        mem_lat = 0;
        do_reset();
        step(1'b1, 27'h7FF_FFFF, 1'b1, 1'b0);
        run_until_valid("t5_wait_max");
        chk("t5_pc_max", {37'd0, instr_pc}, 64'h7FF_FFFF);
        run_until_valid("t5_wait_wrap");
        chk("t5_pc_wrap", {37'd0, instr_pc}, 64'd0);

        // 6: reset while a request is pending with two words buffered.
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 27'd0, 1'b0, 1'b0);
            if (mq.size() == 2) break;
        end
        mem_lat = 7;
        step(1'b0, 27'd0, 1'b0, 1'b0);
        chk("t6_valid_before", {63'd0, instr_valid}, 64'd1);
        chk("t6_req_before", {63'd0, mem_req}, 64'd1);
        do_reset();
        mem_lat = 0;
        run_until_valid("t6_wait_refetch");
        chk("t6_refetch_pc", {37'd0, instr_pc}, 64'd0);

        // Randomized traffic against the reference.
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit f;
            bit rdy;
            bit foa;
            logic [ADDR_W-1:0] fa;
            if (i % 200 == 0) mem_lat = $urandom_range(0, 3);
            if (i == 1500) do_reset();
            f   = ($urandom_range(0, 99) < 3);
            foa = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                fa = 27'h7FF_FFFC + 27'($urandom_range(0, 3));
            end else begin
                fa = 27'($urandom);
            end
            step(f, fa, rdy, foa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
